// File: rtl/cordic_sdiv_30s_16s_17s_seq_if.sv
// Block-level handshake and operand/result bundle for the sequential divider.
// The master drives the request and operands; the slave (divider) drives status and results.
interface cordic_sdiv_30s_16s_17s_seq_if #(
  parameter int din0_WIDTH = 30,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 17
);
  logic                         ap_start;
  logic                         ap_idle;
  logic                         ap_done;
  logic                         ap_ready;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic signed [dout_WIDTH-1:0] dout;
  logic signed [din1_WIDTH-1:0] rem;
  logic                         ovf;
  logic                         dbz;

  modport master (
    output ap_start, din0, din1,
    input  ap_idle, ap_done, ap_ready, dout, rem, ovf, dbz
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_idle, ap_done, ap_ready, dout, rem, ovf, dbz
  );
endinterface

// File: rtl/cordic_sdiv_30s_16s_17s_seq.sv
// Sequential signed divider 30s / 16s -> 17s quotient, 16s remainder, truncating toward zero.
// One radix-2 restoring step per clock, 31-cycle fixed latency, ap_start/ap_done handshake.
// Optional macro CORDIC_DIV_SAT_EN: saturate an overflowing quotient instead of wrapping it.
module cordic_sdiv_30s_16s_17s_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 30,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 17
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  cordic_sdiv_30s_16s_17s_seq_if.slave  bus
);

  localparam int DATA_W = din0_WIDTH;
  localparam int COEF_W = din1_WIDTH;
  localparam int QUOT_W = dout_WIDTH;

  if (ID < 0 || DATA_W != 30 || COEF_W != 16 || QUOT_W != 17) begin : g_bad_cfg
    $error("cordic_sdiv_30s_16s_17s_seq supports only the 30/16/17 configuration");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic        [4:0]          r_cnt;
  logic        [DATA_W-1:0]   r_num;     // dividend bits shift out the top, quotient bits enter the bottom
  logic        [COEF_W-1:0]   r_den;
  logic        [COEF_W-1:0]   r_prem;    // partial remainder, always < |divisor| <= 32768
  logic                       r_sgn_n;
  logic                       r_sgn_q;
  logic                       r_dbz_l;
  logic signed [QUOT_W-1:0]   r_dout;
  logic signed [COEF_W-1:0]   r_rem;
  logic                       r_ovf;
  logic                       r_dbz;

  logic        [DATA_W-1:0]   w_abs0;
  logic        [COEF_W-1:0]   w_abs1;
  logic        [COEF_W:0]     w_trial;
  logic        [COEF_W:0]     w_diff;
  logic                       w_borrow;
  logic        [COEF_W-1:0]   w_prem_nxt;
  logic        [DATA_W-1:0]   w_num_nxt;
  logic                       w_last;
  logic signed [DATA_W:0]     w_q_mag;
  logic signed [DATA_W:0]     w_q_s;
  logic signed [COEF_W-1:0]   w_r_s;
  logic                       w_ovf;

  // Map the signed 31-bit quotient onto 17 bits: clamp or two's-complement wrap.
  function automatic logic signed [QUOT_W-1:0] fit_quot(input logic signed [DATA_W:0] q);
    logic signed [QUOT_W-1:0] res;
    res = $signed(q[QUOT_W-1:0]);
`ifdef CORDIC_DIV_SAT_EN
    if (q > 31'sd65535)
      res = 17'sh0FFFF;
    else if (q < -31'sd65536)
      res = 17'sh10000;
`endif
    return res;
  endfunction

  assign w_abs0     = bus.din0[DATA_W-1] ? (~bus.din0 + 30'd1) : bus.din0;
  assign w_abs1     = bus.din1[COEF_W-1] ? (~bus.din1 + 16'd1) : bus.din1;
  assign w_trial    = {r_prem, r_num[DATA_W-1]};
  assign w_diff     = w_trial - {1'b0, r_den};
  assign w_borrow   = (w_trial < {1'b0, r_den});
  assign w_prem_nxt = w_borrow ? w_trial[COEF_W-1:0] : w_diff[COEF_W-1:0];
  assign w_num_nxt  = {r_num[DATA_W-2:0], ~w_borrow};
  assign w_last     = (r_cnt == 5'd29);
  assign w_q_mag    = $signed({1'b0, w_num_nxt});
  assign w_q_s      = r_sgn_q ? -w_q_mag : w_q_mag;
  assign w_r_s      = r_sgn_n ? -$signed(w_prem_nxt) : $signed(w_prem_nxt);
  assign w_ovf      = (w_q_s > 31'sd65535) || (w_q_s < -31'sd65536);

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic: start only accepted in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.ap_start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.ap_idle  = (r_state == S_IDLE);
    bus.ap_done  = (r_state == S_DONE);
    bus.ap_ready = (r_state == S_DONE);
  end

  // Datapath: latch magnitudes/signs on accept, iterate in CALC, register signed results on the last step.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt   <= '0;
      r_num   <= '0;
      r_den   <= '0;
      r_prem  <= '0;
      r_sgn_n <= 1'b0;
      r_sgn_q <= 1'b0;
      r_dbz_l <= 1'b0;
      r_dout  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.ap_start) begin
        r_num   <= w_abs0;
        r_den   <= w_abs1;
        r_prem  <= '0;
        r_sgn_n <= bus.din0[DATA_W-1];
        r_sgn_q <= bus.din0[DATA_W-1] ^ bus.din1[COEF_W-1];
        r_dbz_l <= (bus.din1 == '0);
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_num  <= w_num_nxt;
        r_prem <= w_prem_nxt;
        r_cnt  <= r_cnt + 5'd1;
        if (w_last) begin
          if (r_dbz_l) begin
            r_dout <= r_sgn_n ? 17'sh10000 : 17'sh0FFFF;
            r_rem  <= '0;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b1;
          end else begin
            r_dout <= fit_quot(w_q_s);
            r_rem  <= w_r_s;
            r_ovf  <= w_ovf;
            r_dbz  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.dout = r_dout;
  assign bus.rem  = r_rem;
  assign bus.ovf  = r_ovf;
  assign bus.dbz  = r_dbz;

endmodule

// File: doc/cordic_sdiv_30s_16s_17s_seq.md
# cordic_sdiv_30s_16s_17s_seq

Iterative signed fixed-point divider for the CORDIC fixed-16 datapath. It is the inverse of the signed 17x16 -> 30 multiply stage. It takes a 30-bit signed dividend and a 16-bit signed divisor and returns a 17-bit signed quotient and a 16-bit signed remainder, truncating toward zero. It is used to renormalise gain-scaled products back to working precision. It is multi-cycle, uses one radix-2 restoring iteration per clock, and has an ap_start/ap_done block-level handshake.

## Interface
- ID, 1, instance identifier; no functional effect
- din0_WIDTH, 30, dividend width; only 30 is supported
- din1_WIDTH, 16, divisor width; only 16 is supported
- dout_WIDTH, 17, quotient width; only 17 is supported

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- ap_start  in  1  request; sampled only in IDLE
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse; results valid
- ap_ready  out  1  identical to ap_done
- din0  in  30  signed dividend
- din1  in  16  signed divisor
- dout  out  17  signed quotient
- rem  out  16  signed remainder
- ovf  out  1  true quotient is outside -65536..65535
- dbz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC when ap_start=1.
  - Latch |din0| (30-bit unsigned) and |din1| (16-bit unsigned).
  - Latch the dividend sign and the quotient sign (sign0 XOR sign1).
  - Clear the iteration counter.
- CALC runs 30 iterations, MSB first:
  - shift the partial remainder left and bring in the next dividend bit;
  - trial-subtract |din1| using a 17-bit compare;
  - on no borrow, keep the difference and shift a 1 into the 30-bit quotient; otherwise shift a 0.
- CALC -> DONE after the 30th iteration. On that edge:
  - apply signs: the quotient is negated if the signs differ; the remainder takes the dividend sign;
  - resolve overflow (see Configuration);
  - register dout, rem, ovf, dbz.
- DONE -> IDLE unconditionally. ap_done=ap_ready=1 for this single cycle.
- Outputs hold their last values until the next DONE.
- Magnitude corner cases: -2^29 and -32768 magnitudes fit the unsigned registers, so no special handling is needed.
- Divisor zero: detected at latch; CALC still runs its full length so latency stays fixed. Result is:
  - dbz=1, ovf=0, rem=0;
  - dout=+65535 if the dividend is >= 0, else -65536. This holds regardless of the macro.
- ap_start while in CALC or DONE is ignored, not queued.
- din0 and din1 are required only in the cycle ap_start is sampled.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, ap_idle=1;
  - ap_done=ap_ready=0;
  - dout=0, rem=0, ovf=0, dbz=0;
  - all internal registers are 0.
- ap_start sampled high in cycle N:
  - ap_idle=0 from cycle N+1;
  - CALC occupies cycles N+1..N+30;
  - ap_done=1 in cycle N+31;
  - ap_idle=1 from cycle N+32.
- Fixed latency of 31 cycles. Back-to-back starts are accepted no more often than every 32 cycles.
- ap_start held high continuously gives a new accept in every IDLE cycle, i.e. every 32 cycles.
- Reset asserted mid-CALC or mid-DONE aborts the operation. No ap_done is produced and outputs return to their reset values.

## Configuration
- CORDIC_DIV_SAT_EN defined: an overflowing quotient clamps to +65535 or -65536 according to the quotient sign. ovf=1.
- Not defined: dout is the low 17 bits of the signed 30-bit quotient (two's-complement wrap). ovf=1 still reported.
- In-range results are identical in both builds.

## Test plan
- 100000 / 7 -> dout=14285, rem=5, ovf=0, dbz=0; ap_done exactly 31 cycles after the start cycle.
- -100000 / 7 -> dout=-14285, rem=-5.
- 100000 / -7 -> dout=-14285, rem=5.
- -536870912 / -32768 -> dout=16384, rem=0.
- 1000000 / 7 -> ovf=1, rem=1. dout=65535 with CORDIC_DIV_SAT_EN defined; 11785 without.
- 1234 / 0 -> dbz=1, dout=65535, rem=0.
- -1234 / 0 -> dbz=1, dout=-65536, rem=0.
- Start 500/3, then pulse ap_start in cycle N+10 -> second request ignored; dout=166, rem=2 at N+31.
- Start a divide, assert ap_rst_n=0 at cycle N+15 -> no ap_done, all outputs 0, ap_idle=1.
